// File: rtl/la_stream_bridge.sv
// Bridge between level-toggled LA strobes and full-rate vld/rdy core channels, FIFO buffered both ways.
// Define LA_SYNC_EN to put 2-flop synchronisers on la_in_vld/la_in_dat/la_out_ack (+2 cycle latency).
module la_sb_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         arst_n,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] wr_dat,
   output logic [W-1:0] rd_dat,
   output logic         empty,
   output logic         full
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          wr_en, rd_en;

   assign empty  = (count == '0);
   assign full   = (count == CW'(DEPTH));
   assign rd_en  = pop & ~empty;
   // A push into a full FIFO is taken only when a pop frees the slot that same cycle.
   assign wr_en  = push & (~full | rd_en);
   assign rd_dat = mem[rd_ptr];

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= wr_dat;
   end
endmodule

module la_stream_bridge #(
   parameter int IN_W      = 12,
   parameter int OUT_W     = 24,
   parameter int IN_DEPTH  = 4,
   parameter int OUT_DEPTH = 4
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic [IN_W-1:0]  la_in_dat,
   input  logic             la_in_vld,
   output logic             la_in_full,
   output logic             la_in_ovf,
   output logic [IN_W-1:0]  chn_in_dat,
   output logic             chn_in_vld,
   input  logic             chn_in_rdy,
   input  logic [OUT_W-1:0] chn_out_dat,
   input  logic             chn_out_vld,
   output logic             chn_out_rdy,
   output logic [OUT_W-1:0] la_out_dat,
   output logic             la_out_vld,
   input  logic             la_out_ack
);
   logic            in_vld_q, out_ack_q;
   logic [IN_W-1:0] in_dat_q;

`ifdef LA_SYNC_EN
   logic [1:0]      in_vld_s, out_ack_s;
   logic [IN_W-1:0] in_dat_s0, in_dat_s1;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         in_vld_s  <= 2'b11;
         out_ack_s <= 2'b11;
         in_dat_s0 <= '0;
         in_dat_s1 <= '0;
      end else begin
         in_vld_s  <= {in_vld_s[0], la_in_vld};
         out_ack_s <= {out_ack_s[0], la_out_ack};
         in_dat_s0 <= la_in_dat;
         in_dat_s1 <= in_dat_s0;
      end
   end

   assign in_vld_q  = in_vld_s[1];
   assign out_ack_q = out_ack_s[1];
   assign in_dat_q  = in_dat_s1;
`else
   assign in_vld_q  = la_in_vld;
   assign out_ack_q = la_out_ack;
   assign in_dat_q  = la_in_dat;
`endif

   // History resets high so a strobe already high at reset release is not an edge.
   logic in_vld_prev, out_ack_prev;
   logic in_evt, out_evt, in_pop, in_empty, out_empty, out_full;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         in_vld_prev  <= 1'b1;
         out_ack_prev <= 1'b1;
      end else begin
         in_vld_prev  <= in_vld_q;
         out_ack_prev <= out_ack_q;
      end
   end

   assign in_evt  = in_vld_q & ~in_vld_prev;
   assign out_evt = out_ack_q & ~out_ack_prev;

   la_sb_fifo #(.W(IN_W), .DEPTH(IN_DEPTH)) u_in_fifo (
      .clk    (clk),
      .arst_n (arst_n),
      .push   (in_evt),
      .pop    (in_pop),
      .wr_dat (in_dat_q),
      .rd_dat (chn_in_dat),
      .empty  (in_empty),
      .full   (la_in_full)
   );

   assign chn_in_vld = ~in_empty;
   assign in_pop     = chn_in_vld & chn_in_rdy;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n)                              la_in_ovf <= 1'b0;
      else if (in_evt & la_in_full & ~in_pop)   la_in_ovf <= 1'b1;
   end

   la_sb_fifo #(.W(OUT_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
      .clk    (clk),
      .arst_n (arst_n),
      .push   (chn_out_vld & chn_out_rdy),
      .pop    (out_evt),
      .wr_dat (chn_out_dat),
      .rd_dat (la_out_dat),
      .empty  (out_empty),
      .full   (out_full)
   );

   assign chn_out_rdy = ~out_full;
   assign la_out_vld  = ~out_empty;
endmodule
